reg_operand_fetch: RTL and testbench

- Read side of the 16 x 16-bit register bank. The bank's write side takes ALU results through one-hot write enables.
- Accepts a pair of source-register addresses through a valid/ready handshake. Returns both operands one cycle later from a registered output stage.
- Forwards a same-cycle bank write into the operands (bypass). Keeps held operands coherent with later writes while downstream stalls.
- Sits between the instruction decoder and the ALU operand latches.

---
 rtl/reg_pkg.sv | 22 ++
 rtl/reg_read_mux.sv | 37 +++
 rtl/reg_operand_fetch.sv | 122 ++++++++++++
 tb/tb_reg_operand_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared register-bank geometry, fetch-stage state type and bank slice helper.
package reg_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  typedef enum logic {
    FETCH_EMPTY = 1'b0,
    FETCH_FULL  = 1'b1
  } fetch_state_e;

  // Extract register idx from the flattened bank (register i at bits [DATA_W*i +: DATA_W]).
  function automatic logic [DATA_W-1:0] get_reg(
    input logic [NREGS*DATA_W-1:0] flat,
    input logic [ADDR_W-1:0]       idx
  );
    return flat[DATA_W*int'(idx) +: DATA_W];
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// One bank read port with same-cycle write bypass. Purely combinational.
module reg_read_mux
  import reg_pkg::*;
#(
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int NREGS  = reg_pkg::NREGS,
  parameter int ADDR_W = reg_pkg::ADDR_W
) (
  input  logic [NREGS*DATA_W-1:0] regs_in,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  output logic [DATA_W-1:0]       rd_data
);

  logic [DATA_W-1:0] bank_val;

  generate
    if (DATA_W == reg_pkg::DATA_W && NREGS == reg_pkg::NREGS && ADDR_W == reg_pkg::ADDR_W) begin : g_pkg
      // Full-size bank: every address is in range, plain slice.
      always_comb bank_val = get_reg(regs_in, addr);
    end else begin : g_generic
      // Reduced bank: addresses beyond NREGS read as zero.
      always_comb begin
        bank_val = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
          if (32'(addr) == i) bank_val = regs_in[i*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  // A write landing this edge wins over the stale bank contents.
  always_comb rd_data = (wb_en && (wb_addr == addr)) ? wb_data : bank_val;

endmodule

// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: valid/ready request in, registered bypassed operand pair out,
// held operands kept coherent with bank writes while stalled, saturating stall counter.
module reg_operand_fetch
  import reg_pkg::*;
#(
  parameter int DATA_W = reg_pkg::DATA_W,
  parameter int NREGS  = reg_pkg::NREGS,
  parameter int ADDR_W = reg_pkg::ADDR_W,
  parameter int CNT_W  = reg_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREGS*DATA_W-1:0] regs_in,
  input  logic                    wb_en,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       rs_addr,
  input  logic [ADDR_W-1:0]       rt_addr,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  input  logic                    stall_clr,
  output logic [CNT_W-1:0]        stall_cnt
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [ADDR_W-1:0] rs_hold_q, rs_hold_d;
  logic [ADDR_W-1:0] rt_hold_q, rt_hold_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [DATA_W-1:0] sel_a, sel_b;
  logic              accept;
  logic              stall;

  reg_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_mux_rs (
    .regs_in (regs_in),
    .addr    (rs_addr),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_data (sel_a)
  );

  reg_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) u_mux_rt (
    .regs_in (regs_in),
    .addr    (rt_addr),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_data (sel_b)
  );

  // Handshake: accept whenever the output slot is free or being drained this edge.
  always_comb begin
    req_ready = !reset && ((state_q == FETCH_EMPTY) || op_ready);
    accept    = req_valid && req_ready;
    stall     = (state_q == FETCH_FULL) && !op_ready;
  end

  // Next-state for the output slot: load on accept, drain on consume, refresh while stalled.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rs_hold_d = rs_hold_q;
    rt_hold_d = rt_hold_q;
    if (accept) begin
      state_d   = FETCH_FULL;
      op_a_d    = sel_a;
      op_b_d    = sel_b;
      rs_hold_d = rs_addr;
      rt_hold_d = rt_addr;
    end else if (state_q == FETCH_FULL) begin
      if (op_ready) begin
        state_d = FETCH_EMPTY;
      end else begin
        if (wb_en && (wb_addr == rs_hold_q)) op_a_d = wb_data;
        if (wb_en && (wb_addr == rt_hold_q)) op_b_d = wb_data;
      end
    end
  end

  // Stall counter: clear beats increment, increment saturates at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH_EMPTY;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rs_hold_q   <= '0;
      rt_hold_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rs_hold_q   <= rs_hold_d;
      rt_hold_q   <= rt_hold_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign op_valid  = (state_q == FETCH_FULL);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: directed cycle table, then randomized traffic against a model.
module tb_reg_operand_fetch;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] regs_in;
  logic         wb_en;
  logic [3:0]   wb_addr;
  logic [15:0]  wb_data;
  logic         req_valid;
  logic         req_ready, req_ready4;
  logic [3:0]   rs_addr, rt_addr;
  logic         op_valid, op_valid4;
  logic         op_ready;
  logic [15:0]  op_a, op_b, op_a4, op_b4;
  logic         stall_clr;
  logic [15:0]  stall_cnt;
  logic [3:0]   stall_cnt4;

  logic [15:0] bank [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) regs_in[i*16 +: 16] = bank[i];
  end

  reg_operand_fetch #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .regs_in(regs_in), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .req_valid(req_valid), .req_ready(req_ready), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt)
  );

  reg_operand_fetch #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .regs_in(regs_in), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .req_valid(req_valid), .req_ready(req_ready4), .rs_addr(rs_addr),
    .rt_addr(rt_addr), .op_valid(op_valid4), .op_ready(op_ready), .op_a(op_a4), .op_b(op_b4),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        rst, rv;
    logic [3:0]  rs, rt;
    logic        ordy, we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        clr;
    logic        e_rdy, e_v;
    logic [15:0] e_a, e_b, e_cnt;
    logic [3:0]  e_cnt4;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  bit          m_v;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_ha, m_hb;
  int          m_cnt, m_cnt4;

  function automatic vec_t mk(logic rst, logic rv, logic [3:0] rs, logic [3:0] rt, logic ordy,
                              logic we, logic [3:0] wa, logic [15:0] wd, logic clr,
                              logic e_rdy, logic e_v, logic [15:0] e_a, logic [15:0] e_b,
                              logic [15:0] e_cnt, logic [3:0] e_cnt4);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rs = rs; v.rt = rt; v.ordy = ordy; v.we = we; v.wa = wa;
    v.wd = wd; v.clr = clr; v.e_rdy = e_rdy; v.e_v = e_v; v.e_a = e_a; v.e_b = e_b;
    v.e_cnt = e_cnt; v.e_cnt4 = e_cnt4;
    return v;
  endfunction

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; req_valid = v.rv; rs_addr = v.rs; rt_addr = v.rt; op_ready = v.ordy;
    wb_en = v.we; wb_addr = v.wa; wb_data = v.wd; stall_clr = v.clr;
  endtask

  function automatic logic [15:0] msel(logic [3:0] x);
    return (wb_en && wb_addr == x) ? wb_data : bank[x];
  endfunction

  // One clock: check ready mid-cycle, advance model from the spec rules, check outputs after edge.
  task automatic run_cycle(input bit use_tbl, input vec_t v, input int step);
    bit mrdy, acc, stl;
    @(negedge clk);
    mrdy = !reset && (!m_v || op_ready);
    chk("req_ready", step, 32'(req_ready), use_tbl ? 32'(v.e_rdy) : 32'(mrdy));
    chk("req_ready4", step, 32'(req_ready4), 32'(mrdy));
    acc = req_valid && mrdy;
    stl = m_v && !op_ready;
    if (reset) begin
      m_v = 0; m_a = '0; m_b = '0; m_ha = '0; m_hb = '0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      if (acc) begin
        m_a = msel(rs_addr); m_b = msel(rt_addr); m_ha = rs_addr; m_hb = rt_addr; m_v = 1;
      end else if (m_v && op_ready) begin
        m_v = 0;
      end else if (stl) begin
        if (wb_en && wb_addr == m_ha) m_a = wb_data;
        if (wb_en && wb_addr == m_hb) m_b = wb_data;
      end
      if (stall_clr) begin
        m_cnt = 0; m_cnt4 = 0;
      end else if (stl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    @(posedge clk);
    #1;
    if (wb_en) bank[wb_addr] = wb_data;
    if (use_tbl) begin
      chk("op_valid", step, 32'(op_valid), 32'(v.e_v));
      chk("op_a", step, 32'(op_a), 32'(v.e_a));
      chk("op_b", step, 32'(op_b), 32'(v.e_b));
      chk("stall_cnt", step, 32'(stall_cnt), 32'(v.e_cnt));
      chk("stall_cnt4", step, 32'(stall_cnt4), 32'(v.e_cnt4));
    end else begin
      chk("op_valid", step, 32'(op_valid), 32'(m_v));
      if (m_v) begin
        chk("op_a", step, 32'(op_a), 32'(m_a));
        chk("op_b", step, 32'(op_b), 32'(m_b));
      end
      chk("stall_cnt", step, 32'(stall_cnt), 32'(m_cnt));
      chk("stall_cnt4", step, 32'(stall_cnt4), 32'(m_cnt4));
      chk("op_valid4", step, 32'(op_valid4), 32'(m_v));
    end
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 16; i++) bank[i] = 16'(i);
    bank[3] = 16'h1234; bank[7] = 16'hBEEF; bank[5] = 16'h1111;
    m_v = 0; m_a = '0; m_b = '0; m_ha = '0; m_hb = '0; m_cnt = 0; m_cnt4 = 0;

    //               rst rv rs rt ordy we wa wd       clr  rdy v  a        b        cnt  cnt4
    tbl.push_back(mk(1, 0, 0, 0, 1,   0, 0, 16'h0,   0,   0,  0, 16'h0,   16'h0,   0,   0));
    tbl.push_back(mk(0, 1, 3, 7, 1,   0, 0, 16'h0,   0,   1,  1, 16'h1234,16'hBEEF,0,   0));
    tbl.push_back(mk(0, 1, 5, 5, 1,   1, 5, 16'h00AA,0,   1,  1, 16'h00AA,16'h00AA,0,   0));
    tbl.push_back(mk(0, 1, 2, 4, 1,   0, 0, 16'h0,   0,   1,  1, 16'h0002,16'h0004,0,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 2, 16'h7777,0,   0,  1, 16'h7777,16'h0004,1,   1));
    tbl.push_back(mk(0, 1, 0, 0, 0,   1, 9, 16'h4444,0,   0,  1, 16'h7777,16'h0004,2,   2));
    tbl.push_back(mk(0, 0, 0, 0, 0,   1, 4, 16'h5555,0,   0,  1, 16'h7777,16'h5555,3,   3));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 16'h0,   0,   0,  1, 16'h7777,16'h5555,4,   4));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 16'h0,   0,   0,  1, 16'h7777,16'h5555,5,   5));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 16'h0,   1,   0,  1, 16'h7777,16'h5555,0,   0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 16'h0,   0,   1,  0, 16'h7777,16'h5555,0,   0));
    tbl.push_back(mk(0, 1, 1, 3, 1,   0, 0, 16'h0,   0,   1,  1, 16'h0001,16'h1234,0,   0));
    tbl.push_back(mk(0, 1, 7, 6, 1,   0, 0, 16'h0,   0,   1,  1, 16'hBEEF,16'h0006,0,   0));
    tbl.push_back(mk(0, 1, 8, 10,1,   0, 0, 16'h0,   0,   1,  1, 16'h0008,16'h000A,0,   0));
    tbl.push_back(mk(0, 1, 15,0, 1,   0, 0, 16'h0,   0,   1,  1, 16'h000F,16'h0000,0,   0));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 16'h0,   0,   1,  0, 16'h000F,16'h0000,0,   0));
    tbl.push_back(mk(0, 1, 11,12,0,   0, 0, 16'h0,   0,   1,  1, 16'h000B,16'h000C,0,   0));
    for (int k = 1; k <= 20; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 1, 16'h000B, 16'h000C, 16'(k), 4'((k > 15) ? 15 : k)));
    tbl.push_back(mk(1, 1, 1, 1, 0,   0, 0, 16'h0,   0,   0,  0, 16'h0,   16'h0,   0,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 16'h0,   0,   1,  0, 16'h0,   16'h0,   0,   0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      run_cycle(1'b1, tbl[i], i);
    end

    for (int n = 0; n < 800; n++) begin
      v.rst  = ($urandom_range(0, 59) == 0);
      v.rv   = $urandom_range(0, 3) != 0;
      v.rs   = 4'($urandom_range(0, 15));
      v.rt   = ($urandom_range(0, 4) == 0) ? v.rs : 4'($urandom_range(0, 15));
      v.ordy = $urandom_range(0, 9) < 6;
      v.we   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0:       v.wa = m_ha;
        1:       v.wa = m_hb;
        2:       v.wa = v.rs;
        default: v.wa = 4'($urandom_range(0, 15));
      endcase
      v.wd   = 16'($urandom);
      v.clr  = ($urandom_range(0, 24) == 0);
      drive(v);
      run_cycle(1'b0, v, 1000 + n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
